// File: rtl/multi_reg_in.sv
// multi_reg_in: debounced write pushbutton loads a switch bank into one of NUM_CH registers
module multi_reg_in #(
  parameter int WIDTH   = 8,
  parameter int NUM_CH  = 4,
  parameter int SEL_W   = 2,
  parameter int DEB_CYC = 4
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [WIDTH-1:0]        IN,
  input  logic [SEL_W-1:0]        SEL,
  input  logic                    AUTO_INC,
  input  logic                    WEN_L,
  output logic [NUM_CH*WIDTH-1:0] OUT,
  output logic [SEL_W-1:0]        PTR,
  output logic                    WR_STB,
  output logic                    WR_ERR
);
  localparam int CW = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYC - 1);
  localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(NUM_CH);
  localparam logic [SEL_W-1:0] PMAX = SEL_W'(NUM_CH - 1);
  logic                    r_s1, r_s2, r_deb, r_stb, r_err;
  logic [CW-1:0]           r_cnt;
  logic [NUM_CH*WIDTH-1:0] r_out;
  logic [SEL_W-1:0]        r_ptr;
  logic                    w_commit, w_ok;
  logic [SEL_W-1:0]        w_tgt;
  // commit is the edge on which the debounced level falls from 1 to 0
  always_comb begin
    w_commit = r_deb & ~r_s2 & (r_cnt == CMAX);
    w_tgt    = AUTO_INC ? r_ptr : SEL;
    w_ok     = AUTO_INC | ({1'b0, SEL} < NCH);
  end
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_s1  <= 1'b1;
      r_s2  <= 1'b1;
      r_deb <= 1'b1;
      r_cnt <= '0;
      r_out <= '0;
      r_ptr <= '0;
      r_stb <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_s1  <= WEN_L;
      r_s2  <= r_s1;
      r_cnt <= (r_s2 == r_deb || r_cnt == CMAX) ? '0 : r_cnt + 1'b1;
      if (r_s2 != r_deb && r_cnt == CMAX) r_deb <= r_s2;
      r_stb <= w_commit & w_ok;
      r_err <= w_commit & ~w_ok;
      if (w_commit && w_ok && AUTO_INC) r_ptr <= (r_ptr == PMAX) ? '0 : r_ptr + 1'b1;
      for (int i = 0; i < NUM_CH; i++)
        if (w_commit && w_ok && w_tgt == SEL_W'(i)) r_out[i*WIDTH +: WIDTH] <= IN;
    end
  end
  assign OUT    = r_out;
  assign PTR    = r_ptr;
  assign WR_STB = r_stb;
  assign WR_ERR = r_err;
endmodule

// File: tb/tb_multi_reg_in.sv
// tb_multi_reg_in: scoreboard bench for the debounced multi-channel register loader
module tb_multi_reg_in;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, auto, wen, stb, err;
  logic [7:0]  in;
  logic [1:0]  sel, ptr;
  logic [31:0] out;
  logic        auto3, wen3, stb3, err3;
  logic [7:0]  in3;
  logic [1:0]  sel3, ptr3;
  logic [23:0] out3;
  multi_reg_in dut (
    .CLK(clk), .RESET_N(rst_n), .IN(in), .SEL(sel), .AUTO_INC(auto), .WEN_L(wen),
    .OUT(out), .PTR(ptr), .WR_STB(stb), .WR_ERR(err)
  );
  multi_reg_in #(.NUM_CH(3)) d3 (
    .CLK(clk), .RESET_N(rst_n), .IN(in3), .SEL(sel3), .AUTO_INC(auto3), .WEN_L(wen3),
    .OUT(out3), .PTR(ptr3), .WR_STB(stb3), .WR_ERR(err3)
  );
  typedef struct packed {logic e; logic [31:0] o; logic [1:0] p;} exp_t;
  exp_t        sb[$];
  exp_t        e_mon;
  logic [31:0] m_out;
  int          m_ptr;
  int          n_chk = 0, n_err = 0, n_stb = 0, n_stb3 = 0, n_err3 = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (stb) n_stb++;
    if (stb3) n_stb3++;
    if (err3) n_err3++;
    if (stb || err) begin
      if (sb.size() == 0) chk("unexpected_strobe", {62'd0, stb, err}, 64'd0);
      else begin
        e_mon = sb.pop_front();
        chk("sb_stb_err", {stb, err}, {~e_mon.e, e_mon.e});
        chk("sb_out", out, e_mon.o);
        chk("sb_ptr", ptr, e_mon.p);
      end
    end
  end
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_out = '0;
    m_ptr = 0;
  endtask
  task automatic press(input logic [7:0] v, input logic a, input logic [1:0] s, input int hold);
    in = v; auto = a; sel = s;
    if (hold >= 4) begin
      if (a) begin
        m_out[m_ptr*8 +: 8] = v;
        m_ptr = (m_ptr + 1) % 4;
      end else m_out[s*8 +: 8] = v;
      sb.push_back('{1'b0, m_out, 2'(m_ptr)});
    end
    wen = 1'b0;
    repeat (hold) @(negedge clk);
    wen = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; wen = 1'b1; auto = 1'b0; sel = '0; in = '0;
    wen3 = 1'b1; auto3 = 1'b0; sel3 = '0; in3 = '0;
    m_out = '0; m_ptr = 0;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_ptr", ptr, 0);
    chk("rst_strobes", {stb, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // fixed-latency write to channel 2: commit lands on edge 5
    in = 8'hA5; sel = 2'd2; auto = 1'b0;
    m_out[23:16] = 8'hA5;
    sb.push_back('{1'b0, m_out, 2'd0});
    wen = 1'b0;
    repeat (5) @(negedge clk);
    chk("lat_edge4", {out[23:16], stb}, 9'h000);
    @(negedge clk);
    chk("lat_edge5", {out[23:16], stb}, {8'hA5, 1'b1});
    repeat (14) @(negedge clk);
    wen = 1'b1;
    repeat (8) @(negedge clk);
    chk("single_write", out, 32'h00A5_0000);
    chk("one_strobe", n_stb, 1);
    press(8'hFF, 1'b0, 2'd0, 3);
    chk("short_out", out, 32'h00A5_0000);
    chk("short_strobe", n_stb, 1);
    do_reset();
    for (int i = 0; i < 5; i++) press(8'((i + 1) * 17), 1'b1, 2'd0, 6);
    chk("auto_out", out, 32'h4433_2255);
    chk("auto_ptr", ptr, 1);
    chk("auto_strobes", n_stb, 6);
    // release bounce after a committed press
    in = 8'h77; sel = 2'd1; auto = 1'b0;
    m_out[15:8] = 8'h77;
    sb.push_back('{1'b0, m_out, 2'(m_ptr)});
    wen = 1'b0;
    repeat (8) @(negedge clk);
    wen = 1'b1; @(negedge clk);
    wen = 1'b0; @(negedge clk);
    wen = 1'b1; @(negedge clk);
    wen = 1'b0; @(negedge clk);
    wen = 1'b1;
    repeat (12) @(negedge clk);
    chk("bounce_strobes", n_stb, 7);
    chk("bounce_out", out, 32'h4433_7755);
    // reset on the commit edge wins
    in = 8'hC3; sel = 2'd0; wen = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_priority", {out, ptr, stb}, 0);
    wen = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; m_out = '0; m_ptr = 0;
    repeat (10) @(negedge clk);
    chk("rst_priority_strobes", n_stb, 7);
    press(8'h5C, 1'b1, 2'd0, 6);
    chk("pre_mid_rst", {out, ptr}, {32'h0000_005C, 2'd1});
    // reset at cnt=2 with the button still held, then a fresh commit
    in = 8'h3C; sel = 2'd3; auto = 1'b0; wen = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", {out, ptr, stb}, 0);
    m_out = 32'h3C00_0000; m_ptr = 0;
    sb.push_back('{1'b0, m_out, 2'd0});
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("fresh_edge4", {out, stb}, 0);
    @(negedge clk);
    chk("fresh_edge5", {out, stb}, {32'h3C00_0000, 1'b1});
    wen = 1'b1;
    repeat (10) @(negedge clk);
    chk("fresh_strobes", n_stb, 9);
    // three-channel instance: out-of-range SEL is rejected
    auto3 = 1'b1; in3 = 8'h5A; wen3 = 1'b0;
    repeat (6) @(negedge clk);
    wen3 = 1'b1;
    repeat (8) @(negedge clk);
    chk("d3_write", {out3, ptr3}, {24'h00_005A, 2'd1});
    chk("d3_stb", n_stb3, 1);
    auto3 = 1'b0; sel3 = 2'd3; in3 = 8'hEE; wen3 = 1'b0;
    repeat (8) @(negedge clk);
    wen3 = 1'b1;
    repeat (8) @(negedge clk);
    chk("d3_err_cycles", n_err3, 1);
    chk("d3_unchanged", {out3, ptr3}, {24'h00_005A, 2'd1});
    chk("d3_no_stb", n_stb3, 1);
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
